display_mode_arbiter: RTL and testbench
=======================================

Name: display_mode_arbiter

Overview:
- Owns the shared VGA/seg/beep/key path between the pinball engine (game) and the piano engine (piano).
- Turns the raw mode switch into a glitch-free, frame-aligned handover:
  - blank the display on a frame boundary of the outgoing source;
  - hold the incoming engine in reset, then release it;
  - unblank after N clean frames of the new source.
- Sits between the top-level switches and the output muxes; its outputs drive the mux selects and the per-engine resets.

Parameters:
- DEB_CYCLES, 500000, sys_clk cycles mode_sw must be stable before a change is accepted (counter width = clog2(DEB_CYCLES+1)).
- RST_CYCLES, 16, cycles the incoming engine is held in reset.
- BLANK_FRAMES, 2, falling vs edges of the new source counted before unblank (≥1).
- VS_TIMEOUT, 2000000, max cycles waited for any single vs edge before proceeding anyway.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- mode_sw  in  1  raw switch, asynchronous; 1 = game, 0 = piano.
- vs_game  in  1  game vertical sync, active-low, sys_clk domain.
- vs_piano  in  1  piano vertical sync, active-low, sys_clk domain.
- mode_sel  out  1  registered mux select; 1 = game drives outputs.
- blank  out  1  force rgb to 0 and seg off while high.
- game_rst_n  out  1  active-low reset to game engine.
- piano_rst_n  out  1  active-low reset to piano engine.
- beep_mute  out  1  gates beep; equals blank.
- key_en  out  1  routes move keys to the active engine; low while switching.
- busy  out  1  high in any non-idle state.

Behaviour:
- Clock and reset:
  - One clock, sys_clk. Reset is synchronous and active-low on rst_n.
- Reset values:
  - mode_sel=0, blank=1, beep_mute=1, key_en=0, busy=1.
  - game_rst_n=0, piano_rst_n=0.
  - State RST_NEW with target=piano, all counters 0.
  - So after reset the piano is brought up through the normal path.
- Input synchronisation and debounce:
  - mode_sw passes a 2-flop synchroniser.
  - Debounce counter resets whenever the synced value ≠ the candidate value.
  - sw_db updates to the candidate when the counter reaches DEB_CYCLES-1.
  - Latency from a clean edge to sw_db change: 2 + DEB_CYCLES cycles.
- Vs edge detect:
  - Registered; fall_x = prev_vs_x & ~vs_x.
  - Only the source currently being watched is used.
- FSM states:
  - IDLE: busy=0, blank=0, key_en=1.
    - Active engine out of reset; inactive engine held in reset.
    - If sw_db ≠ mode_sel → DRAIN, with target=sw_db.
  - DRAIN: key_en=0.
    - Waits for fall of the currently selected source, or timeout.
    - On that event: blank=1, then → SWAP.
  - SWAP: one cycle.
    - mode_sel←target; both engine resets asserted (0).
    - → RST_NEW.
  - RST_NEW: hold the target engine reset low for RST_CYCLES cycles.
    - Then release the target engine only → WAIT_NEW with frame counter=0.
  - WAIT_NEW: count falls of the target source.
    - A timeout counts as one frame.
    - At count==BLANK_FRAMES: blank=0, key_en=1 → IDLE.
- Timeout:
  - A per-wait cycle counter clears on entering DRAIN or WAIT_NEW, and after every counted frame.
  - Reaching VS_TIMEOUT-1 is treated as an edge.
- Switch toggles during a switch:
  - Ignored until IDLE. The transition completes to the latched target.
  - IDLE then compares sw_db again, so a toggle back triggers a fresh switch.
  - Switch bounce never causes a partial swap.
- Simultaneous events:
  - If fall and timeout occur in the same cycle, count one frame.
  - A fall in the cycle of entering WAIT_NEW is not counted; counting starts the next cycle.
- Reset mid-operation:
  - rst_n low in any state → reset values next edge, regardless of counters.
- Output invariants:
  - mode_sel changes only in SWAP, and only while blank=1.
  - At most one engine reset is deasserted at any time.
  - beep_mute ≡ blank.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, DRAIN, SWAP, RST_NEW, WAIT_NEW (3-bit);
  - MODE_PIANO=0 and MODE_GAME=1.
- One sub-module: sw_debounce.
  - Synchroniser plus counter, parameter DEB_CYCLES.
  - Inputs sys_clk, rst_n, raw. Output stable level.
  - Reused for rst/key inputs elsewhere.

Test Plan:
- Bench params for all scenarios: DEB_CYCLES=4, RST_CYCLES=3, BLANK_FRAMES=1, VS_TIMEOUT=64. vs period 20 cycles.
- 1. Reset release, mode_sw=0:
  - after RST_CYCLES, piano_rst_n=1;
  - first vs_piano fall → blank=0, key_en=1, mode_sel=0;
  - game_rst_n stays 0.
- 2. Clean 0→1 on mode_sw:
  - sw_db rises 6 cycles later; DRAIN is entered;
  - on next vs_piano fall, blank=1;
  - next cycle mode_sel=1 and both resets=0;
  - game_rst_n=1 three cycles later;
  - after one vs_game fall, blank=0, busy=0.
- 3. mode_sw glitch high for 3 cycles → no state change, mode_sel stays 0, busy stays 0.
- 4. vs_game held constant during WAIT_NEW → unblank occurs exactly 64 cycles after entering WAIT_NEW (timeout path).
- 5. Toggle mode_sw back to 0 during RST_NEW of a piano→game switch:
  - the switch completes to game (IDLE reached);
  - then a game→piano switch starts;
  - mode_sel sequence is 0→1→0, with blank=1 at each change.
- 6. rst_n pulsed low for 1 cycle during WAIT_NEW → next edge shows all reset values; the piano bring-up restarts.

Source files
------------

// File: rtl/display_mode_arbiter_pkg.sv
// Shared definitions for the display mode arbiter.
//   state_t    : handover FSM states (3-bit encoding)
//   MODE_PIANO : mux select value that routes the piano engine to the outputs
//   MODE_GAME  : mux select value that routes the pinball engine to the outputs
package display_mode_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DRAIN    = 3'd1,
        SWAP     = 3'd2,
        RST_NEW  = 3'd3,
        WAIT_NEW = 3'd4
    } state_t;

    localparam logic MODE_PIANO = 1'b0;
    localparam logic MODE_GAME  = 1'b1;

endpackage

// File: rtl/display_mode_arbiter_sw_debounce.sv
// Two-flop synchroniser followed by a stability counter.
//   sys_clk : clock
//   rst_n   : synchronous active-low reset (output resets to 0)
//   raw     : asynchronous input level
//   stable  : accepted level; follows raw once the synced value has differed
//             from it for DEB_CYCLES consecutive cycles
// Edge-to-output latency is 2 + DEB_CYCLES cycles.
module sw_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // Any cycle where the synced level agrees with the accepted one
            // restarts the count, so bounces shorter than DEB_CYCLES vanish.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_mode_arbiter.sv
// Frame-aligned handover of the shared VGA/seg/beep/key path between the
// pinball (game) and piano engines.
//   sys_clk     : clock, all logic on rising edge
//   rst_n       : synchronous active-low reset
//   mode_sw     : raw mode switch (1 = game, 0 = piano), asynchronous
//   vs_game     : game vsync, active-low
//   vs_piano    : piano vsync, active-low
//   mode_sel    : registered output mux select (1 = game)
//   blank       : forces rgb/seg off
//   game_rst_n  : active-low reset to the game engine
//   piano_rst_n : active-low reset to the piano engine
//   beep_mute   : beep gate, identical to blank
//   key_en      : routes move keys to the active engine
//   busy        : high whenever a handover is in progress
module display_mode_arbiter
    import display_mode_arbiter_pkg::*;
#(
    parameter int DEB_CYCLES   = 500000,
    parameter int RST_CYCLES   = 16,
    parameter int BLANK_FRAMES = 2,
    parameter int VS_TIMEOUT   = 2000000
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic mode_sw,
    input  logic vs_game,
    input  logic vs_piano,
    output logic mode_sel,
    output logic blank,
    output logic game_rst_n,
    output logic piano_rst_n,
    output logic beep_mute,
    output logic key_en,
    output logic busy
);

    localparam int RW = $clog2(RST_CYCLES + 1);
    localparam int TW = $clog2(VS_TIMEOUT + 1);
    localparam int FW = $clog2(BLANK_FRAMES + 1);
    localparam logic [RW-1:0] RST_LAST   = RW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST    = TW'(VS_TIMEOUT - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLANK_FRAMES - 1);

    logic sw_db;

    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sw_debounce (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .raw     (mode_sw),
        .stable  (sw_db)
    );

    state_t        state, state_nxt;
    logic          target, target_nxt;
    logic          mode_sel_nxt, blank_nxt, key_en_nxt;
    logic          game_rst_n_nxt, piano_rst_n_nxt;
    logic [RW-1:0] rst_cnt, rst_cnt_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;
    logic [FW-1:0] frame_cnt, frame_cnt_nxt;
    logic          prev_vs_game, prev_vs_piano;

    // Only the source currently on the mux is watched: in DRAIN that is the
    // outgoing engine, in WAIT_NEW mode_sel already equals the target.
    logic fall_watch, to_hit, vs_event;
    assign fall_watch = mode_sel ? (prev_vs_game & ~vs_game)
                                 : (prev_vs_piano & ~vs_piano);
    assign to_hit     = (to_cnt == TO_LAST);
    assign vs_event   = fall_watch | to_hit;

    assign busy      = (state != IDLE);
    assign beep_mute = blank;

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state         <= RST_NEW;
            target        <= MODE_PIANO;
            mode_sel      <= MODE_PIANO;
            blank         <= 1'b1;
            key_en        <= 1'b0;
            game_rst_n    <= 1'b0;
            piano_rst_n   <= 1'b0;
            rst_cnt       <= '0;
            to_cnt        <= '0;
            frame_cnt     <= '0;
            prev_vs_game  <= 1'b1;
            prev_vs_piano <= 1'b1;
        end else begin
            state         <= state_nxt;
            target        <= target_nxt;
            mode_sel      <= mode_sel_nxt;
            blank         <= blank_nxt;
            key_en        <= key_en_nxt;
            game_rst_n    <= game_rst_n_nxt;
            piano_rst_n   <= piano_rst_n_nxt;
            rst_cnt       <= rst_cnt_nxt;
            to_cnt        <= to_cnt_nxt;
            frame_cnt     <= frame_cnt_nxt;
            prev_vs_game  <= vs_game;
            prev_vs_piano <= vs_piano;
        end
    end

    always_comb begin
        state_nxt       = state;
        target_nxt      = target;
        mode_sel_nxt    = mode_sel;
        blank_nxt       = blank;
        key_en_nxt      = key_en;
        game_rst_n_nxt  = game_rst_n;
        piano_rst_n_nxt = piano_rst_n;
        rst_cnt_nxt     = rst_cnt;
        to_cnt_nxt      = to_cnt;
        frame_cnt_nxt   = frame_cnt;

        case (state)
            IDLE: begin
                // The target is latched here; later switch activity is not
                // looked at again until the handover is back in IDLE.
                if (sw_db != mode_sel) begin
                    target_nxt = sw_db;
                    key_en_nxt = 1'b0;
                    to_cnt_nxt = '0;
                    state_nxt  = DRAIN;
                end
            end
            DRAIN: begin
                if (vs_event) begin
                    blank_nxt = 1'b1;
                    state_nxt = SWAP;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            SWAP: begin
                // Both engines go into reset together, so there is never a
                // cycle with the new select and the old engine still running.
                mode_sel_nxt    = target;
                game_rst_n_nxt  = 1'b0;
                piano_rst_n_nxt = 1'b0;
                rst_cnt_nxt     = '0;
                state_nxt       = RST_NEW;
            end
            RST_NEW: begin
                if (rst_cnt == RST_LAST) begin
                    game_rst_n_nxt  = (target == MODE_GAME);
                    piano_rst_n_nxt = (target == MODE_PIANO);
                    frame_cnt_nxt   = '0;
                    to_cnt_nxt      = '0;
                    state_nxt       = WAIT_NEW;
                end else begin
                    rst_cnt_nxt = rst_cnt + 1'b1;
                end
            end
            WAIT_NEW: begin
                // A fall and a timeout in the same cycle count as one frame.
                if (vs_event) begin
                    to_cnt_nxt = '0;
                    if (frame_cnt == FRAME_LAST) begin
                        blank_nxt  = 1'b0;
                        key_en_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        frame_cnt_nxt = frame_cnt + 1'b1;
                    end
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            default: begin
                // Unreachable encodings restart the piano bring-up.
                mode_sel_nxt    = MODE_PIANO;
                target_nxt      = MODE_PIANO;
                blank_nxt       = 1'b1;
                key_en_nxt      = 1'b0;
                game_rst_n_nxt  = 1'b0;
                piano_rst_n_nxt = 1'b0;
                rst_cnt_nxt     = '0;
                state_nxt       = RST_NEW;
            end
        endcase
    end

endmodule

// File: tb/tb_display_mode_arbiter.sv
// Scoreboard bench: the stimulus process predicts every output change of the
// handover (cycle and value) from the frame/timeout rules and the known vsync
// waveforms; a separate monitor pops a prediction whenever the outputs change.
module tb_display_mode_arbiter;

    localparam int DEB = 4;
    localparam int RST = 3;
    localparam int BF  = 1;
    localparam int TO  = 64;
    localparam int PER = 20;
    localparam logic [5:0] RESET_V = 6'b010001;

    logic sys_clk = 1'b0;
    logic rst_n, mode_sw, vs_game, vs_piano;
    logic mode_sel, blank, game_rst_n, piano_rst_n, beep_mute, key_en, busy;

    always #5 sys_clk = ~sys_clk;

    display_mode_arbiter #(
        .DEB_CYCLES(DEB), .RST_CYCLES(RST), .BLANK_FRAMES(BF), .VS_TIMEOUT(TO)
    ) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .mode_sw(mode_sw),
        .vs_game(vs_game), .vs_piano(vs_piano),
        .mode_sel(mode_sel), .blank(blank), .game_rst_n(game_rst_n),
        .piano_rst_n(piano_rst_n), .beep_mute(beep_mute), .key_en(key_en),
        .busy(busy)
    );

    // {mode_sel, blank, game_rst_n, piano_rst_n, key_en, busy}
    logic [5:0] dut_vec;
    assign dut_vec = {mode_sel, blank, game_rst_n, piano_rst_n, key_en, busy};

    typedef struct {
        int         cyc;
        logic [5:0] vec;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   ph_g, ph_p;
    bit   hold_g = 1'b0;
    bit   hold_p = 1'b0;
    int   idle_cyc;
    bit   cur_mode;

    // vsync: low for 2 cycles out of every PER, or parked high when held
    function automatic logic vs_at(input bit g, input int c);
        if (g ? hold_g : hold_p) return 1'b1;
        return ((c + (g ? ph_g : ph_p)) % PER) >= 2;
    endfunction

    // First cycle >= a in which the watched source is seen falling, or the
    // cycle at which the wait times out.
    function automatic int next_event(input bit g, input int a);
        for (int c = a; c < a + TO - 1; c++)
            if (!vs_at(g, c) && vs_at(g, c - 1)) return c;
        return a + TO - 1;
    endfunction

    task automatic push(input int c, input logic [5:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
        cyc++;
        vs_game  = vs_at(1'b1, cyc);
        vs_piano = vs_at(1'b0, cyc);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Predicted output sequence of one handover to t. sw_vis is the first
    // cycle the debounced switch shows t; idle_from the first IDLE cycle.
    task automatic plan_switch(input bit t, input int sw_vis, input int idle_from,
                               input bit stop_at_wait,
                               output int e, output int w, output int idle_at);
        bit old;
        int d;
        old = !t;
        d = ((sw_vis > idle_from) ? sw_vis : idle_from) + 1;
        push(d, {old, 1'b0, old, !old, 1'b0, 1'b1});            // drain
        e = next_event(old, d);
        push(e + 1, {old, 1'b1, old, !old, 1'b0, 1'b1});        // blanked
        push(e + 2, {t, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1});          // swapped
        w = e + 2 + RST;
        push(w, {t, 1'b1, t, !t, 1'b0, 1'b1});                   // released
        idle_at = 0;
        if (!stop_at_wait) begin
            idle_at = next_event(t, w) + 1;
            push(idle_at, {t, 1'b0, t, !t, 1'b1, 1'b0});         // unblanked
        end
    endtask

    // rst_n high from cycle r: piano comes up through the normal path
    task automatic bring_up(input int r);
        push(r + RST, 6'b010101);
        idle_cyc = next_event(1'b0, r + RST) + 1;
        push(idle_cyc, 6'b000110);
    endtask

    task automatic do_switch(input bit t);
        int e, w, u;
        mode_sw = t;
        plan_switch(t, cyc + DEB + 2, idle_cyc, 1'b0, e, w, u);
        idle_cyc = u;
        cur_mode = t;
        run_to(idle_cyc + int'($urandom_range(3, 30)));
    endtask

    // Monitor: compares each output change against the next prediction.
    initial begin
        logic [5:0] last;
        exp_t ex;
        last = RESET_V;
        forever begin
            @(negedge sys_clk);
            if (!mon_en) begin
                last = RESET_V;
            end else begin
                checks++;
                if (beep_mute !== blank || (game_rst_n === 1'b1 && piano_rst_n === 1'b1) ||
                    (dut_vec[5] !== last[5] && !(blank === 1'b1 && last[4] === 1'b1))) begin
                    errors++;
                    $display("FAIL invariant cycle %0d got=%b beep_mute=%b prev=%b",
                             cyc, dut_vec, beep_mute, last);
                end
                if (dut_vec !== last) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change cycle %0d got=%b", cyc, dut_vec);
                    end else begin
                        ex = q.pop_front();
                        if (ex.cyc != cyc || ex.vec !== dut_vec) begin
                            errors++;
                            $display("FAIL event got=%b at cycle %0d expected=%b at cycle %0d",
                                     dut_vec, cyc, ex.vec, ex.cyc);
                        end
                    end
                    last = dut_vec;
                end
            end
        end
    end

    initial begin
        int e, w, u, c1, p;
        ph_g = int'($urandom_range(0, PER - 1));
        ph_p = int'($urandom_range(0, PER - 1));
        rst_n    = 1'b0;
        mode_sw  = 1'b0;
        vs_game  = vs_at(1'b1, 0);
        vs_piano = vs_at(1'b0, 0);
        cur_mode = 1'b0;

        // reset state
        repeat (3) step();
        check("reset_outputs", dut_vec, RESET_V);
        check("reset_beep_mute", {5'b0, beep_mute}, 6'd1);
        mon_en = 1'b1;
        step();

        // 1: piano bring-up after reset
        rst_n = 1'b1;
        bring_up(cyc);
        run_to(idle_cyc + 5);
        check("bringup_idle", dut_vec, 6'b000110);

        // 3: short glitches never reach the FSM
        for (int i = 0; i < 3; i++) begin
            mode_sw = 1'b1;
            repeat (int'($urandom_range(1, DEB - 1))) step();
            mode_sw = 1'b0;
            repeat (12) step();
            check("glitch_ignored", {4'b0, mode_sel, busy}, 6'b0);
        end

        // 2: clean piano->game, then back
        do_switch(1'b1);
        check("game_idle", dut_vec, 6'b101010);
        do_switch(1'b0);

        // 4: game vsync parked high, unblank on timeout
        hold_g = 1'b1;
        do_switch(1'b1);
        hold_g = 1'b0;
        step();
        do_switch(1'b0);

        // 5: switch flipped back while the game engine is held in reset
        mode_sw = 1'b1;
        plan_switch(1'b1, cyc + DEB + 2, idle_cyc, 1'b0, e, w, u);
        c1 = e + 2 + int'($urandom_range(0, RST - 1));
        run_to(c1);
        mode_sw = 1'b0;
        plan_switch(1'b0, c1 + DEB + 2, u, 1'b0, e, w, idle_cyc);
        cur_mode = 1'b0;
        run_to(idle_cyc + 10);
        check("toggle_back_idle", dut_vec, 6'b000110);

        // 6: reset pulse while waiting for piano frames
        do_switch(1'b1);
        hold_p = 1'b1;
        mode_sw = 1'b0;
        plan_switch(1'b0, cyc + DEB + 2, idle_cyc, 1'b1, e, w, u);
        p = w + int'($urandom_range(0, 40));
        run_to(p);
        rst_n = 1'b0;
        hold_p = 1'b0;
        push(p + 1, RESET_V);
        step();
        check("midop_reset", dut_vec, RESET_V);
        rst_n = 1'b1;
        cur_mode = 1'b0;
        bring_up(cyc);
        run_to(idle_cyc + 5);

        // a few more random handovers
        for (int i = 0; i < 4; i++) do_switch(!cur_mode);

        run_to(cyc + 10);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_events got=%0d pending expected=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
